// File: rtl/alu.sv
// Single-cycle-latency ALU for an RV32I-style datapath.
// The result is formed combinationally from the operands and the decoder
// operation class, then registered together with a zero flag on each edge.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUOp,
    input  logic [2:0]  funct3,
    output logic [31:0] Result,
    output logic        zero
);

    localparam logic [2:0] OP_ADDR   = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_R      = 3'b010;
    localparam logic [2:0] OP_R_ALT  = 3'b011;
    localparam logic [2:0] OP_I      = 3'b100;
    localparam logic [2:0] OP_LUI    = 3'b101;
    localparam logic [2:0] OP_PASS_A = 3'b110;

    logic [4:0]  shamt;
    logic        use_sub;
    logic        use_sra;
    logic        lt_signed;
    logic        lt_unsigned;
    logic        taken;
    logic [31:0] arith_result;
    logic [31:0] next_result;

    // Shared comparators; both branch and set-less-than forms use them.
    always_comb begin
        shamt       = B[4:0];
        lt_signed   = $signed(A) < $signed(B);
        lt_unsigned = A < B;
    end

    // Alternate-form selects: SUB only exists for R-type with funct7[5]=1,
    // while SRA is picked by funct7[5] for R-type and by imm bit 10 for I-type.
    always_comb begin
        use_sub = (ALUOp == OP_R_ALT);
        use_sra = (ALUOp == OP_R_ALT) || ((ALUOp == OP_I) && B[10]);
    end

    // Branch condition evaluation; the two unused funct3 codes never take.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (A == B);
            3'b001:  taken = (A != B);
            3'b100:  taken = lt_signed;
            3'b101:  taken = !lt_signed;
            3'b110:  taken = lt_unsigned;
            3'b111:  taken = !lt_unsigned;
            default: taken = 1'b0;
        endcase
    end

    // Integer arithmetic/logic shared by the R-type and I-type classes.
    always_comb begin
        arith_result = 32'h0;
        case (funct3)
            3'b000:  arith_result = use_sub ? (A - B) : (A + B);
            3'b001:  arith_result = A << shamt;
            3'b010:  arith_result = {31'b0, lt_signed};
            3'b011:  arith_result = {31'b0, lt_unsigned};
            3'b100:  arith_result = A ^ B;
            3'b101:  arith_result = use_sra ? $unsigned($signed(A) >>> shamt)
                                            : (A >> shamt);
            3'b110:  arith_result = A | B;
            3'b111:  arith_result = A & B;
            default: arith_result = 32'h0;
        endcase
    end

    // Operation-class mux producing the value loaded on the next edge.
    always_comb begin
        next_result = 32'h0;
        case (ALUOp)
            OP_ADDR:   next_result = A + B;
            OP_BRANCH: next_result = {31'b0, taken};
            OP_R:      next_result = arith_result;
            OP_R_ALT:  next_result = arith_result;
            OP_I:      next_result = arith_result;
            OP_LUI:    next_result = B;
            OP_PASS_A: next_result = A;
            default:   next_result = 32'h0;
        endcase
    end

    // Output register; reset clears the pending result immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result <= 32'h0;
            zero   <= 1'b1;
        end else begin
            Result <= next_result;
            zero   <= (next_result == 32'h0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector and reference-model bench for the registered ALU.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic [2:0]  funct3;
    logic [31:0] Result;
    logic        zero;

    int total;
    int bad;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .ALUOp  (ALUOp),
        .funct3 (funct3),
        .Result (Result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Reference model written independently of the RTL structure.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sa, sb, srl_v, sra_v, fill;
        int s;
        s     = int'(b[4:0]);
        sa    = a ^ 32'h8000_0000;
        sb    = b ^ 32'h8000_0000;
        srl_v = a >> s;
        fill  = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        sra_v = srl_v | fill;
        if (op == 3'd0) return a + b;
        if (op == 3'd5) return b;
        if (op == 3'd6) return a;
        if (op == 3'd7) return 32'h0;
        if (op == 3'd1) begin
            case (f3)
                3'd0: return (a == b) ? 32'd1 : 32'd0;
                3'd1: return (a != b) ? 32'd1 : 32'd0;
                3'd4: return (sa < sb) ? 32'd1 : 32'd0;
                3'd5: return (sa >= sb) ? 32'd1 : 32'd0;
                3'd6: return (a < b) ? 32'd1 : 32'd0;
                3'd7: return (a >= b) ? 32'd1 : 32'd0;
                default: return 32'h0;
            endcase
        end
        case (f3)
            3'd0: return (op == 3'd3) ? a + (~b + 32'd1) : a + b;
            3'd1: return a << s;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (op == 3'd3 || (op == 3'd4 && b[10])) return sra_v;
                return srl_v;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_q;
        total  = 0;
        bad    = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        A      = 32'h0;
        B      = 32'h0;
        ALUOp  = 3'd0;
        funct3 = 3'd0;

        vecs.push_back('{3'b000, 3'b101, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_wrap_sign"});
        vecs.push_back('{3'b011, 3'b000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, "sub_equal"});
        vecs.push_back('{3'b011, 3'b101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, "r_sra"});
        vecs.push_back('{3'b010, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg"});
        vecs.push_back('{3'b010, 3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_big"});
        vecs.push_back('{3'b001, 3'b000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001, "beq_taken"});
        vecs.push_back('{3'b001, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "bltu_not"});
        vecs.push_back('{3'b100, 3'b101, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000, "srai"});
        vecs.push_back('{3'b100, 3'b101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, "srli"});
        vecs.push_back('{3'b101, 3'b011, 32'h0000_0123, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lui"});
        vecs.push_back('{3'b110, 3'b001, 32'hCAFE_F00D, 32'h1111_1111, 32'hCAFE_F00D, "pass_a"});
        vecs.push_back('{3'b111, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "reserved"});
        vecs.push_back('{3'b010, 3'b001, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020, "sll_low5"});
        vecs.push_back('{3'b010, 3'b101, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, "srl_zero"});
        vecs.push_back('{3'b011, 3'b001, 32'h0000_0003, 32'h0000_0002, 32'h0000_000C, "alt_sll"});
        vecs.push_back('{3'b100, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "addi_wrap"});
        vecs.push_back('{3'b001, 3'b101, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, "bge_neg"});
        vecs.push_back('{3'b001, 3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "bgeu_big"});
        vecs.push_back('{3'b001, 3'b010, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, "br_f3_010"});
        vecs.push_back('{3'b001, 3'b100, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, "blt_min"});
        vecs.push_back('{3'b001, 3'b001, 32'h0000_0007, 32'h0000_0008, 32'h0000_0001, "bne"});
        vecs.push_back('{3'b011, 3'b000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap"});
        vecs.push_back('{3'b010, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor"});
        vecs.push_back('{3'b010, 3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "or"});
        vecs.push_back('{3'b010, 3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and"});
        vecs.push_back('{3'b100, 3'b010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "slti"});
        vecs.push_back('{3'b010, 3'b000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "add_zero"});

        // Reset state while rst held, before any clock edge.
        #2;
        check32("reset_result", Result, 32'h0);
        check1("reset_zero", zero, 1'b1);
        // Inputs present during reset must not load while rst is high.
        A     = 32'h0000_0009;
        ALUOp = 3'b110;
        @(posedge clk); #1;
        check32("reset_hold_result", Result, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check32("first_edge_load", Result, 32'h0000_0009);
        check1("first_edge_zero", zero, 1'b0);

        // Directed vector table.
        foreach (vecs[i]) begin
            A      = vecs[i].a;
            B      = vecs[i].b;
            ALUOp  = vecs[i].op;
            funct3 = vecs[i].f3;
            @(posedge clk); #1;
            check32(vecs[i].name, Result, vecs[i].exp);
            check1({vecs[i].name, "_zero"}, zero, vecs[i].exp == 32'h0);
        end

        // Asynchronous reset between edges while Result holds 5.
        A = 32'h0000_0005; ALUOp = 3'b110;
        @(posedge clk); #1;
        check32("pre_async_result", Result, 32'h0000_0005);
        #2 rst = 1'b1;
        #1;
        check32("async_rst_result", Result, 32'h0);
        check1("async_rst_zero", zero, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check32("rst_release_hold", Result, 32'h0);
        @(posedge clk); #1;
        check32("rst_release_load", Result, 32'h0000_0005);

        // Back-to-back sweep of every ALUOp/funct3 code, one new result per edge.
        for (int code = 0; code < 64; code++) begin
            A      = $urandom;
            B      = $urandom;
            if (code % 4 == 0) B = A;
            ALUOp  = code[5:3];
            funct3 = code[2:0];
            exp_q  = ref_alu(ALUOp, funct3, A, B);
            @(posedge clk); #1;
            check32($sformatf("sweep_op%0d_f%0d", code[5:3], code[2:0]), Result, exp_q);
            check1($sformatf("sweep_zero_%0d", code), zero, exp_q == 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: A  input  32  operand 1 (rs1 / PC).
REQ-004 SHALL have port: B  input  32  operand 2 (rs2 / immediate).
REQ-005 SHALL have port: ALUOp  input  3  operation class from main decoder.
REQ-006 SHALL have port: funct3  input  3  instruction funct3 field.
REQ-007 SHALL have port: Result  output  32  registered ALU result.
REQ-008 SHALL have port: zero  output  1  registered flag, 1 when Result == 0.
REQ-009 SHALL have no parameters; all widths fixed at 32 bits.

Function
REQ-010 SHALL compute the next result combinationally from A, B, ALUOp, funct3 and register it into Result on each rising clk edge; latency exactly 1 cycle, new result every cycle.
REQ-011 SHALL register zero in the same edge as Result, with zero = (next Result == 0).
REQ-012 ALUOp 000 (load/store/addr): SHALL produce A + B, modulo 2^32, funct3 ignored.
REQ-013 ALUOp 001 (branch): SHALL produce {31'b0, taken}; taken per funct3: 000 A==B, 001 A!=B, 100 signed A<B, 101 signed A>=B, 110 unsigned A<B, 111 unsigned A>=B, 010/011 taken=0.
REQ-014 ALUOp 010 (R-type, funct7[5]=0): funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-015 ALUOp 011 (R-type, funct7[5]=1): funct3 000 SUB (A - B mod 2^32), 101 SRA; all other funct3 as REQ-014.
REQ-016 ALUOp 100 (I-type arith): funct3 as REQ-014 except funct3 101 SHALL select SRA when B[10]=1, SRL when B[10]=0; no SUB form.
REQ-017 ALUOp 101 (LUI): SHALL produce B unchanged.
REQ-018 ALUOp 110 (pass A): SHALL produce A unchanged.
REQ-019 ALUOp 111 (reserved): SHALL produce 0.
REQ-020 Shifts SHALL use only B[4:0] as amount; SRA replicates A[31]; amount 0 returns A.
REQ-021 SLT/SLTU SHALL produce 1 or 0 in bit 0, upper 31 bits zero; SLT two's-complement, SLTU unsigned.
REQ-022 Add/sub overflow SHALL wrap silently; no carry/overflow outputs.
REQ-023 Any X-free input combination SHALL yield a defined result; no latches.

Reset
REQ-024 While rst=1 (asynchronous assert, independent of clk), Result SHALL be 0x00000000 and zero SHALL be 1.
REQ-025 After rst deasserts, the first rising clk edge SHALL load the computed result; reset asserted mid-stream SHALL discard the pending result immediately.

Verification
REQ-026 ALUOp=000, A=0x7FFFFFFF, B=1 -> after 1 edge Result=0x80000000, zero=0.
REQ-027 ALUOp=011, funct3=000, A=5, B=5 -> Result=0, zero=1; funct3=101, A=0x80000000, B=4 -> Result=0xF8000000.
REQ-028 ALUOp=010, funct3=010, A=0xFFFFFFFF, B=1 -> Result=1; funct3=011 same operands -> Result=0.
REQ-029 ALUOp=001: funct3=000, A=B=0x1234 -> Result=1; funct3=110, A=0xFFFFFFFF, B=1 -> Result=0, zero=1.
REQ-030 ALUOp=100, funct3=101, A=0x80000000, B=0x404 -> Result=0xF8000000; B=0x004 -> 0x08000000.
REQ-031 Drive rst=1 between clock edges while Result=0x5 -> Result=0, zero=1 immediately; sweep all 64 ALUOp/funct3 codes with random A,B against a reference model, 1-cycle lag.
